spi_reg_ctrl: RTL and testbench

//   Write-only SPI peripheral that configures the output-enable, PWM-enable and

---
 rtl/spi_reg_ctrl.sv | 147 ++++++++++++++
 tb/tb_spi_reg_ctrl.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_ctrl.sv
// SPI write-only register bank for the PWM datapath.
// Pins are synchronized to clk; 16-bit frames commit in a single COMMIT cycle.
module spi_reg_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_ADDR    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       wr_done
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } state_t;

  localparam int         HI    = SYNC_STAGES;
  localparam logic [6:0] MAX_A = 7'(MAX_ADDR);

  logic [HI:0] sclk_q;
  logic [HI:0] copi_q;
  logic [HI:0] ncs_q;

  logic        sclk_rise;
  logic        ncs_rise;
  logic        ncs_fall;
  logic        copi_bit;

  state_t      state_q;
  state_t      state_d;
  logic        clr;
  logic        shift;
  logic        commit;

  logic [4:0]  cnt;
  logic [15:0] sr;
  logic [6:0]  addr;
  logic [7:0]  data;
  logic        wr_ok;

  // Synchronizer chains; the top bit of each is the history flop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_q <= '0;
      copi_q <= '0;
      ncs_q  <= '1;
    end else begin
      sclk_q <= {sclk_q[HI-1:0], sclk};
      copi_q <= {copi_q[HI-1:0], copi};
      ncs_q  <= {ncs_q[HI-1:0], ncs};
    end
  end

  // COPI is taken from the history flop, aligned with the pre-edge SCLK level.
  assign sclk_rise = sclk_q[HI-1] & ~sclk_q[HI];
  assign ncs_rise  = ncs_q[HI-1] & ~ncs_q[HI];
  assign ncs_fall  = ~ncs_q[HI-1] & ncs_q[HI];
  assign copi_bit  = copi_q[HI];

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and datapath strobes; ncs rise outranks a same-cycle SCLK rise.
  always_comb begin
    state_d = state_q;
    clr     = 1'b0;
    shift   = 1'b0;
    commit  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ncs_fall) begin
          state_d = SHIFT;
          clr     = 1'b1;
        end
      end
      SHIFT: begin
        if (ncs_rise) state_d = COMMIT;
        else if (sclk_rise) shift = 1'b1;
      end
      COMMIT: begin
        commit = 1'b1;
        if (ncs_fall) begin
          state_d = SHIFT;
          clr     = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Shift register and saturating bit counter (17 flags an overlong frame).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
      sr  <= '0;
    end else if (clr) begin
      cnt <= '0;
      sr  <= '0;
    end else if (shift) begin
      sr <= {sr[14:0], copi_bit};
      if (cnt != 5'd17) cnt <= cnt + 5'd1;
    end
  end

  assign addr  = sr[14:8];
  assign data  = sr[7:0];
  assign wr_ok = commit && (cnt == 5'd16) && sr[15] && (addr <= MAX_A);

  // Register bank; loads only from a valid frame in COMMIT.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      en_reg_out_7_0  <= '0;
      en_reg_out_15_8 <= '0;
      en_reg_pwm_7_0  <= '0;
      en_reg_pwm_15_8 <= '0;
      pwm_duty_cycle  <= '0;
      wr_done         <= 1'b0;
    end else begin
      wr_done <= wr_ok;
      if (wr_ok) begin
        unique case (1'b1)
          addr == 7'd0: en_reg_out_7_0  <= data;
          addr == 7'd1: en_reg_out_15_8 <= data;
          addr == 7'd2: en_reg_pwm_7_0  <= data;
          addr == 7'd3: en_reg_pwm_15_8 <= data;
          addr == 7'd4: pwm_duty_cycle  <= data;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Directed bench for spi_reg_ctrl.
// Bit-bangs SPI frames and checks the register bank and wr_done.
module tb_spi_reg_ctrl;

  localparam int SYNC = 2;
  localparam int H    = SYNC + 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sclk = 1'b0;
  logic       copi = 1'b0;
  logic       ncs = 1'b1;
  logic [7:0] en_reg_out_7_0;
  logic [7:0] en_reg_out_15_8;
  logic [7:0] en_reg_pwm_7_0;
  logic [7:0] en_reg_pwm_15_8;
  logic [7:0] pwm_duty_cycle;
  logic       wr_done;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;

  spi_reg_ctrl #(
    .SYNC_STAGES(SYNC),
    .MAX_ADDR   (4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .sclk           (sclk),
    .copi           (copi),
    .ncs            (ncs),
    .en_reg_out_7_0 (en_reg_out_7_0),
    .en_reg_out_15_8(en_reg_out_15_8),
    .en_reg_pwm_7_0 (en_reg_pwm_7_0),
    .en_reg_pwm_15_8(en_reg_pwm_15_8),
    .pwm_duty_cycle (pwm_duty_cycle),
    .wr_done        (wr_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (wr_done === 1'b1) done_cnt++;

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    ncs = 1'b0;
    clks(H);
  endtask

  task automatic shift_bits(input logic [15:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      copi = (i < 16) ? w[15 - i] : 1'b1;
      clks(H);
      sclk = 1'b1;
      clks(H);
      sclk = 1'b0;
    end
    clks(H);
  endtask

  task automatic stop_frame();
    ncs = 1'b1;
    clks(SYNC + 6);
  endtask

  task automatic send_frame(input logic [15:0] w, input int n);
    start_frame();
    shift_bits(w, n);
    stop_frame();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sclk = 1'($urandom);
      copi = 1'($urandom);
      ncs  = 1'($urandom);
      clks(1);
    end
    n_tests++;
    if ({en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0,
         en_reg_pwm_15_8, pwm_duty_cycle} !== 40'h0) begin
      n_fail++;
      $display("FAIL reset_regs: got %h want 0", {en_reg_out_7_0,
               en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8,
               pwm_duty_cycle});
    end
    n_tests++;
    if (wr_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_wr_done: got %b want 0", wr_done);
    end
    sclk = 1'b0;
    copi = 1'b0;
    ncs  = 1'b1;
    clks(SYNC + 3);
    rst_n = 1'b1;
    clks(SYNC + 3);
  endtask

  task automatic test_write_out();
    int d0;
    d0 = done_cnt;
    send_frame(16'h8001, 16);
    n_tests++;
    if (en_reg_out_7_0 !== 8'h01) begin
      n_fail++;
      $display("FAIL out_first: got %h want 01", en_reg_out_7_0);
    end
    send_frame(16'h80F0, 16);
    n_tests++;
    if (en_reg_out_7_0 !== 8'hF0) begin
      n_fail++;
      $display("FAIL out_second: got %h want F0", en_reg_out_7_0);
    end
    n_tests++;
    if (done_cnt - d0 !== 2) begin
      n_fail++;
      $display("FAIL out_done: got %0d want 2", done_cnt - d0);
    end
    n_tests++;
    if ({en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8,
         pwm_duty_cycle} !== 32'h0) begin
      n_fail++;
      $display("FAIL out_others: got %h want 0", {en_reg_out_15_8,
               en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle});
    end
  endtask

  task automatic test_latency_read();
    int d0;
    start_frame();
    shift_bits(16'h8480, 16);
    ncs = 1'b1;
    clks(SYNC + 1);
    n_tests++;
    if (pwm_duty_cycle !== 8'h00 || wr_done !== 1'b0) begin
      n_fail++;
      $display("FAIL lat_early: got %h/%b want 00/0",
               pwm_duty_cycle, wr_done);
    end
    clks(1);
    n_tests++;
    if (pwm_duty_cycle !== 8'h80 || wr_done !== 1'b1) begin
      n_fail++;
      $display("FAIL lat_exact: got %h/%b want 80/1",
               pwm_duty_cycle, wr_done);
    end
    clks(1);
    n_tests++;
    if (wr_done !== 1'b0) begin
      n_fail++;
      $display("FAIL lat_pulse: got %b want 0", wr_done);
    end
    clks(SYNC + 4);
    d0 = done_cnt;
    send_frame(16'h0455, 16);
    n_tests++;
    if (pwm_duty_cycle !== 8'h80 || done_cnt != d0) begin
      n_fail++;
      $display("FAIL read_frame: got %h/%0d want 80/0",
               pwm_duty_cycle, done_cnt - d0);
    end
  endtask

  task automatic test_bad_addr();
    int d0;
    logic [39:0] snap;
    snap = {en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0,
            en_reg_pwm_15_8, pwm_duty_cycle};
    d0 = done_cnt;
    send_frame(16'h8533, 16);
    send_frame(16'hFF11, 16);
    n_tests++;
    if ({en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0,
         en_reg_pwm_15_8, pwm_duty_cycle} !== 40'hF0_00_00_00_80) begin
      n_fail++;
      $display("FAIL bad_addr_regs: got %h want %h", {en_reg_out_7_0,
               en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8,
               pwm_duty_cycle}, snap);
    end
    n_tests++;
    if (done_cnt != d0) begin
      n_fail++;
      $display("FAIL bad_addr_done: got %0d want 0", done_cnt - d0);
    end
  endtask

  task automatic test_frame_length();
    int d0;
    d0 = done_cnt;
    send_frame(16'h82AA, 15);
    send_frame(16'h82AA, 17);
    n_tests++;
    if (en_reg_pwm_7_0 !== 8'h00 || done_cnt != d0) begin
      n_fail++;
      $display("FAIL bad_len: got %h/%0d want 00/0",
               en_reg_pwm_7_0, done_cnt - d0);
    end
    send_frame(16'h82AA, 16);
    n_tests++;
    if (en_reg_pwm_7_0 !== 8'hAA || done_cnt != d0 + 1) begin
      n_fail++;
      $display("FAIL clean_len: got %h/%0d want AA/1",
               en_reg_pwm_7_0, done_cnt - d0);
    end
  endtask

  task automatic test_idle_sclk();
    for (int i = 0; i < 3; i++) begin
      sclk = 1'b1;
      copi = 1'b1;
      clks(H);
      sclk = 1'b0;
      clks(H);
    end
    send_frame(16'h8103, 16);
    n_tests++;
    if (en_reg_out_15_8 !== 8'h03) begin
      n_fail++;
      $display("FAIL idle_sclk: got %h want 03", en_reg_out_15_8);
    end
  endtask

  task automatic test_reset_mid_frame();
    start_frame();
    shift_bits(16'h83CC, 8);
    rst_n = 1'b0;
    clks(2);
    n_tests++;
    if ({en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0,
         en_reg_pwm_15_8, pwm_duty_cycle, wr_done} !== 41'h0) begin
      n_fail++;
      $display("FAIL mid_reset: got %h want 0", {en_reg_out_7_0,
               en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8,
               pwm_duty_cycle, wr_done});
    end
    ncs = 1'b1;
    copi = 1'b0;
    clks(SYNC + 3);
    rst_n = 1'b1;
    clks(SYNC + 3);
    n_tests++;
    if (en_reg_pwm_15_8 !== 8'h00) begin
      n_fail++;
      $display("FAIL post_reset: got %h want 00", en_reg_pwm_15_8);
    end
    send_frame(16'h83CC, 16);
    n_tests++;
    if (en_reg_pwm_15_8 !== 8'hCC || en_reg_out_7_0 !== 8'h00) begin
      n_fail++;
      $display("FAIL after_reset: got %h/%h want CC/00",
               en_reg_pwm_15_8, en_reg_out_7_0);
    end
  endtask

  task automatic test_back_to_back();
    int d0;
    d0 = done_cnt;
    start_frame();
    shift_bits(16'h8155, 16);
    ncs = 1'b1;
    clks(SYNC + 1);
    ncs = 1'b0;
    clks(H);
    shift_bits(16'h8466, 16);
    stop_frame();
    n_tests++;
    if (en_reg_out_15_8 !== 8'h55 || pwm_duty_cycle !== 8'h66) begin
      n_fail++;
      $display("FAIL b2b_regs: got %h/%h want 55/66",
               en_reg_out_15_8, pwm_duty_cycle);
    end
    n_tests++;
    if (done_cnt != d0 + 2) begin
      n_fail++;
      $display("FAIL b2b_done: got %0d want 2", done_cnt - d0);
    end
  endtask

  initial begin
    test_reset();
    test_write_out();
    test_latency_read();
    test_bad_addr();
    test_frame_length();
    test_idle_sclk();
    test_reset_mid_frame();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
